gray_binary_codec_pipe: RTL and testbench

Parametrised, pipelined bidirectional converter between Gray code and binary, with a per-transaction direction select. Uses a valid/ready handshake on both sides and carries full backpressure. For Gray-to-binary traffic it also checks the Gray single-step property and counts violations. It sits behind CDC pointer/counter synchronisers and in front of any logic that consumes binary counts.

---
 rtl/gray_codec_pkg.sv | 50 +++++
 rtl/gray_binary_codec_pipe_if.sv | 17 +
 rtl/gray_codec_stage.sv | 65 ++++++
 rtl/gray_binary_codec_pipe.sv | 95 +++++++++
 tb/tb_gray_binary_codec_pipe.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_codec_pkg.sv
// Shared types and bit-twiddling helpers for the Gray/binary codec pipe.
// Helpers take a MAX_W-wide word plus the live width.
package gray_codec_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    GRAY2BIN = 1'b0,
    BIN2GRAY = 1'b1
  } codec_mode_e;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b,
    input int               w
  );
    logic [MAX_W-1:0] g;
    g = b ^ (b >> 1);
    for (int i = 0; i < MAX_W; i++)
      if (i >= w) g[i] = 1'b0;
    return g;
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g,
    input int               w
  );
    logic [MAX_W-1:0] b;
    logic             c;
    b = '0;
    c = 1'b0;
    for (int i = MAX_W-1; i >= 0; i--)
      if (i < w) begin
        c    = c ^ g[i];
        b[i] = c;
      end
    return b;
  endfunction

  function automatic int popcount(
    input logic [MAX_W-1:0] x,
    input int               w
  );
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w && x[i]) n++;
    return n;
  endfunction

endpackage

// File: rtl/gray_binary_codec_pipe_if.sv
// Valid/ready stream carrying a codec word and its direction.
// master drives the payload, slave returns ready.
interface gray_binary_codec_pipe_if
  import gray_codec_pkg::*;
#(
    parameter int N = 8
) ();

    logic        valid;
    logic        ready;
    codec_mode_e mode;
    logic [N-1:0] data;

    modport master (output valid, output mode, output data, input ready);
    modport slave  (input valid, input mode, input data, output ready);

endinterface

// File: rtl/gray_codec_stage.sv
// One pipeline slice: resolves its chunk of Gray bits (or encodes
// binary in slice 1) and holds valid/mode/data/err with backpressure.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int IDX    = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_vld,
    input  codec_mode_e  in_mode,
    input  logic [N-1:0] in_data,
    input  logic         in_err,
    input  logic         nxt_ld,
    output logic         ld,
    output logic         vld,
    output codec_mode_e  mode,
    output logic [N-1:0] data,
    output logic         err
);

    localparam int CHUNK = (N + STAGES - 1) / STAGES;
    localparam int HI    = N - 1 - (IDX - 1) * CHUNK;
    localparam int LO    = (N - IDX * CHUNK > 0) ? N - IDX * CHUNK : 0;

    logic [N-1:0] conv;
    logic         c;

    // Bits above HI are already binary; bits below LO are still raw Gray.
    always_comb begin
        conv = in_data;
        c    = 1'b0;
        if (in_mode == BIN2GRAY) begin
            if (IDX == 1) conv = N'(bin2gray(MAX_W'(in_data), N));
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i > HI) begin
                    c = in_data[i];
                end else if (i >= LO) begin
                    conv[i] = c ^ in_data[i];
                    c       = conv[i];
                end
            end
        end
    end

    assign ld = !vld || nxt_ld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld  <= 1'b0;
            mode <= GRAY2BIN;
            data <= '0;
            err  <= 1'b0;
        end else if (ld) begin
            vld  <= in_vld;
            mode <= in_mode;
            data <= conv;
            err  <= in_err;
        end
    end

endmodule

// File: rtl/gray_binary_codec_pipe.sv
// Pipelined bidirectional Gray/binary converter with Gray step checking
// and a saturating count of step violations seen at the output.
module gray_binary_codec_pipe
  import gray_codec_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int ERR_W  = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    gray_binary_codec_pipe_if.slave  in_if,
    gray_binary_codec_pipe_if.master out_if,
    output logic                     step_err,
    output logic [ERR_W-1:0]         err_cnt
);

    logic [N-1:0] hist;
    logic         hist_valid;
    logic         acc;
    logic         err_in;

    assign acc    = in_if.valid && in_if.ready;
    assign err_in = (in_if.mode == GRAY2BIN) && hist_valid &&
                    (popcount(MAX_W'(in_if.data ^ hist), N) > 1);

    for (genvar k = 1; k <= STAGES; k++) begin : g_stg
        logic         pv, pe, nld, ld, vld, err;
        codec_mode_e  pm, mode;
        logic [N-1:0] pd, data;

        if (k == 1) begin : g_head
            assign pv = in_if.valid;
            assign pm = in_if.mode;
            assign pd = in_if.data;
            assign pe = err_in;
        end else begin : g_body
            assign pv = g_stg[k-1].vld;
            assign pm = g_stg[k-1].mode;
            assign pd = g_stg[k-1].data;
            assign pe = g_stg[k-1].err;
        end

        if (k == STAGES) begin : g_tail
            assign nld = out_if.ready;
        end else begin : g_link
            assign nld = g_stg[k+1].ld;
        end

        gray_codec_stage #(
            .N      (N),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .in_vld  (pv),
            .in_mode (pm),
            .in_data (pd),
            .in_err  (pe),
            .nxt_ld  (nld),
            .ld      (ld),
            .vld     (vld),
            .mode    (mode),
            .data    (data),
            .err     (err)
        );
    end

    assign in_if.ready  = g_stg[1].ld;
    assign out_if.valid = g_stg[STAGES].vld;
    assign out_if.mode  = g_stg[STAGES].mode;
    assign out_if.data  = g_stg[STAGES].data;
    assign step_err     = g_stg[STAGES].err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist       <= '0;
            hist_valid <= 1'b0;
        end else if (acc && in_if.mode == GRAY2BIN) begin
            hist       <= in_if.data;
            hist_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (out_if.valid && out_if.ready && step_err &&
                     err_cnt != {ERR_W{1'b1}}) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_binary_codec_pipe.sv
// Directed bench for gray_binary_codec_pipe at N=4, STAGES=2, ERR_W=2.
// Vector table plus hand-written backpressure, reset and saturation runs.
module tb_gray_binary_codec_pipe;
    import gray_codec_pkg::*;

    logic       clk;
    logic       rstn;
    logic       step_err;
    logic [1:0] err_cnt;

    gray_binary_codec_pipe_if #(.N(4)) in_if ();
    gray_binary_codec_pipe_if #(.N(4)) out_if ();

    gray_binary_codec_pipe #(
        .N      (4),
        .STAGES (2),
        .ERR_W  (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_if    (in_if),
        .out_if   (out_if),
        .step_err (step_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        codec_mode_e m;
        logic [3:0]  din;
        logic [3:0]  dout;
        logic        err;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl [11];
    int   nvec = 0;
    int   nbad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Called #1 after a rising edge with out_ready high; returns after
    // the consume edge so err_cnt already reflects this item.
    task automatic xfer(input codec_mode_e m, input logic [3:0] din,
                        output logic [3:0] dout, output codec_mode_e dm,
                        output logic de);
        in_if.valid = 1'b1;
        in_if.mode  = m;
        in_if.data  = din;
        #1;
        chk("in_ready", int'(in_if.ready), 1);
        @(posedge clk);
        #1 in_if.valid = 1'b0;
        chk("lat_early", int'(out_if.valid), 0);
        @(posedge clk);
        #1;
        chk("lat_valid", int'(out_if.valid), 1);
        dout = out_if.data;
        dm   = out_if.mode;
        de   = step_err;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  od, g;
    codec_mode_e om;
    logic        oe, acc, cons;
    int          nacc, ncons, cyc;
    logic [3:0]  items [6];
    logic [3:0]  expg  [6];
    logic [3:0]  sseq  [6];
    logic [1:0]  scnt  [6];

    initial begin
        tbl[0]  = '{1'b0, GRAY2BIN, 4'b0110, 4'b0100, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, GRAY2BIN, 4'b1111, 4'b1010, 1'b1, 2'd1};
        tbl[2]  = '{1'b0, BIN2GRAY, 4'b0100, 4'b0110, 1'b0, 2'd1};
        tbl[3]  = '{1'b0, BIN2GRAY, 4'b1010, 4'b1111, 1'b0, 2'd1};
        tbl[4]  = '{1'b1, GRAY2BIN, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, GRAY2BIN, 4'b0001, 4'b0001, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, GRAY2BIN, 4'b0011, 4'b0010, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, GRAY2BIN, 4'b0011, 4'b0010, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, GRAY2BIN, 4'b0101, 4'b0110, 1'b1, 2'd1};
        tbl[9]  = '{1'b0, BIN2GRAY, 4'b1111, 4'b1000, 1'b0, 2'd1};
        tbl[10] = '{1'b0, GRAY2BIN, 4'b0100, 4'b0111, 1'b0, 2'd1};
        items = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        expg  = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5};
        sseq  = '{4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0011};
        scnt  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        in_if.mode = GRAY2BIN;
        in_if.data = '0;
        do_reset();
        chk("rst_valid", int'(out_if.valid), 0);
        chk("rst_data", int'(out_if.data), 0);
        chk("rst_mode", int'(out_if.mode), 0);
        chk("rst_err", int'(step_err), 0);
        chk("rst_cnt", int'(err_cnt), 0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            xfer(tbl[i].m, tbl[i].din, od, om, oe);
            chk($sformatf("v%0d_data", i), int'(od), int'(tbl[i].dout));
            chk($sformatf("v%0d_mode", i), int'(om), int'(tbl[i].m));
            chk($sformatf("v%0d_err", i), int'(oe), int'(tbl[i].err));
            chk($sformatf("v%0d_cnt", i), int'(err_cnt), int'(tbl[i].cnt));
        end

        for (int v = 0; v < 16; v++) begin
            xfer(BIN2GRAY, 4'(v), g, om, oe);
            xfer(GRAY2BIN, g, od, om, oe);
            chk($sformatf("rt%0d", v), int'(od), v);
        end

        do_reset();
        out_if.ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            in_if.valid = 1'b1;
            in_if.mode  = BIN2GRAY;
            in_if.data  = items[nacc];
            #1;
            acc = in_if.ready;
            if (c >= 2) begin
                chk("bp_ready", int'(in_if.ready), 0);
                chk("bp_valid", int'(out_if.valid), 1);
                chk("bp_hold", int'(out_if.data), 1);
            end
            @(posedge clk);
            if (acc) nacc++;
            #1;
        end
        chk("bp_nacc", nacc, 2);

        out_if.ready = 1'b1;
        ncons = 0;
        cyc   = 0;
        while (ncons < 6 && cyc < 20) begin
            in_if.valid = (nacc < 6);
            if (nacc < 6) in_if.data = items[nacc];
            #1;
            acc  = in_if.valid && in_if.ready;
            cons = out_if.valid;
            od   = out_if.data;
            @(posedge clk);
            if (acc) nacc++;
            if (cons) begin
                chk($sformatf("bp_out%0d", ncons), int'(od), int'(expg[ncons]));
                ncons++;
            end
            cyc++;
            #1;
        end
        in_if.valid = 1'b0;
        chk("bp_count", ncons, 6);
        chk("bp_rate", cyc, 6);
        chk("bp_accepted", nacc, 6);
        chk("bp_drain", int'(out_if.valid), 0);

        do_reset();
        xfer(GRAY2BIN, 4'b0000, od, om, oe);
        xfer(GRAY2BIN, 4'b1111, od, om, oe);
        chk("mr_cnt_pre", int'(err_cnt), 1);
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.mode   = GRAY2BIN;
        in_if.data   = 4'b0001;
        @(posedge clk);
        #1 in_if.data = 4'b0011;
        @(posedge clk);
        #1 in_if.valid = 1'b0;
        chk("mr_full", int'(out_if.valid), 1);
        rstn = 1'b0;
        #1;
        chk("mr_valid", int'(out_if.valid), 0);
        chk("mr_cnt", int'(err_cnt), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        out_if.ready = 1'b1;
        xfer(GRAY2BIN, 4'b0111, od, om, oe);
        chk("mr_data", int'(od), 5);
        chk("mr_err", int'(oe), 0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            xfer(GRAY2BIN, sseq[i], od, om, oe);
            chk($sformatf("sat%0d_err", i), int'(oe), (i == 0) ? 0 : 1);
            chk($sformatf("sat%0d_cnt", i), int'(err_cnt), int'(scnt[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
